// File: rtl/track_screen_pkg.sv
// Shared types and defaults for the multi-player race track renderer.
// Colours are packed {G,R,B} bytes, player 0 in the least significant slot.
package track_screen_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  localparam int MAX_PLAYERS = 8;

  // Players 0..3: green, red, blue, yellow; 4..7: cyan, magenta, white, orange.
  localparam logic [24*MAX_PLAYERS-1:0] DEFAULT_COLORS = {
    24'h030800, 24'h030303, 24'h000505, 24'h050005,
    24'h050500, 24'h00000A, 24'h000A00, 24'h0A0000
  };

  function automatic rgb_t HALF(input rgb_t c);
    rgb_t h;
    h.g = c.g >> 1;
    h.r = c.r >> 1;
    h.b = c.b >> 1;
    return h;
  endfunction

endpackage

// File: rtl/player_trail_tracker.sv
// Per-player frame-synchronous position capture and fading trail bookkeeping.
// Reports whether the player or its live trail sits on the requested LED.
module player_trail_tracker #(
  parameter int MAX_POS      = 109,
  parameter int POS_W        = $clog2(MAX_POS),
  parameter int TRAIL_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [POS_W-1:0] position,
  input  logic [POS_W-1:0] led_number,
  output logic [POS_W-1:0] cur_pos,
  output logic             hit,
  output logic             trail_hit
);

  localparam int TC_W = (TRAIL_FRAMES > 0) ? $clog2(TRAIL_FRAMES + 1) : 1;

  logic [POS_W-1:0] cur_pos_reg;
  logic [POS_W-1:0] trail_pos_reg;
  logic [TC_W-1:0]  trail_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_pos_reg   <= '0;
      trail_pos_reg <= '0;
      trail_cnt_reg <= '0;
    end else if (frame_tick) begin
      if (position != cur_pos_reg) begin
        trail_pos_reg <= cur_pos_reg;
        cur_pos_reg   <= position;
        trail_cnt_reg <= TC_W'(TRAIL_FRAMES);
      end else if (trail_cnt_reg != '0) begin
        trail_cnt_reg <= trail_cnt_reg - TC_W'(1);
      end
    end
  end

  assign cur_pos = cur_pos_reg;

  // Positions beyond the strip are legal but never light anything.
  assign hit       = (cur_pos_reg == led_number) && (int'(cur_pos_reg) < MAX_POS);
  assign trail_hit = (trail_cnt_reg != '0) && (trail_pos_reg == led_number) &&
                     (int'(trail_pos_reg) < MAX_POS);

endmodule

// File: rtl/multi_player_track_screen.sv
// N-player gameplay screen: leader detection, blink phase, per-LED priority mux
// and the registered intensity bus (pass-through when disabled).
module multi_player_track_screen
  import track_screen_pkg::*;
#(
  parameter int N_PLAYERS                      = 4,
  parameter int MAX_POS                        = 109,
  parameter logic [24*N_PLAYERS-1:0] PLAYER_COLORS = DEFAULT_COLORS[24*N_PLAYERS-1:0],
  parameter int TRAIL_FRAMES                   = 8,
  parameter int BLINK_FRAMES                   = 16,
  parameter int COLLISION_LEVEL                = 5,
  localparam int POS_W                         = $clog2(MAX_POS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       frame_tick,
  input  logic [N_PLAYERS*POS_W-1:0] positions,
  input  logic [POS_W-1:0]           led_number,
  input  logic [7:0]                 i_red_intensity,
  input  logic [7:0]                 i_blue_intensity,
  input  logic [7:0]                 i_green_intensity,
  output logic [7:0]                 o_red_intensity,
  output logic [7:0]                 o_blue_intensity,
  output logic [7:0]                 o_green_intensity
);

  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [POS_W-1:0]     cur_pos [N_PLAYERS];
  logic [N_PLAYERS-1:0] hit;
  logic [N_PLAYERS-1:0] trail_hit;
  logic [N_PLAYERS-1:0] leader;
  logic [POS_W-1:0]     max_pos;

  logic [BC_W-1:0] blink_cnt_reg;
  logic            blink_on_reg;
  rgb_t            render;
  rgb_t            out_reg;
  logic [3:0]      hit_count;

  generate
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
      player_trail_tracker #(
        .MAX_POS     (MAX_POS),
        .POS_W       (POS_W),
        .TRAIL_FRAMES(TRAIL_FRAMES)
      ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .position  (positions[gi*POS_W +: POS_W]),
        .led_number(led_number),
        .cur_pos   (cur_pos[gi]),
        .hit       (hit[gi]),
        .trail_hit (trail_hit[gi])
      );

      // A race where nobody has left the start line has no leader.
      assign leader[gi] = (max_pos != '0) && (cur_pos[gi] == max_pos);
    end
  endgenerate

  always_comb begin
    max_pos = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (cur_pos[p] > max_pos) max_pos = cur_pos[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (frame_tick && (BLINK_FRAMES != 0)) begin
      if (blink_cnt_reg == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= ~blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BC_W'(1);
      end
    end
  end

  always_comb begin
    render    = '0;
    hit_count = '0;
    for (int p = 0; p < N_PLAYERS; p++) hit_count = hit_count + 4'(hit[p]);

    if (hit_count >= 4'd2) begin
      render.g = 8'(COLLISION_LEVEL);
      render.r = 8'(COLLISION_LEVEL);
      render.b = 8'(COLLISION_LEVEL);
    end else if (hit_count == 4'd1) begin
      for (int p = 0; p < N_PLAYERS; p++) begin
        if (hit[p]) begin
          render = rgb_t'(PLAYER_COLORS[p*24 +: 24]);
          if (leader[p] && (BLINK_FRAMES != 0) && !blink_on_reg) render = HALF(render);
        end
      end
    end else begin
      // Descending scan so the lowest-index trail wins.
      for (int p = N_PLAYERS - 1; p >= 0; p--) begin
        if (trail_hit[p]) render = HALF(rgb_t'(PLAYER_COLORS[p*24 +: 24]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else if (!enable) begin
      out_reg.g <= i_green_intensity;
      out_reg.r <= i_red_intensity;
      out_reg.b <= i_blue_intensity;
    end else begin
      out_reg <= render;
    end
  end

  assign o_green_intensity = out_reg.g;
  assign o_red_intensity   = out_reg.r;
  assign o_blue_intensity  = out_reg.b;

endmodule

// File: tb/tb_multi_player_track_screen.sv
// Directed plus randomized bench for multi_player_track_screen, checked against
// a frame-level behavioural model of players, trails and the blink phase.
module tb_multi_player_track_screen;

  localparam int N     = 4;
  localparam int MAXP  = 109;
  localparam int PW    = 7;
  localparam int TRAIL = 8;
  localparam int BLINK = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            frame_tick;
  logic [N*PW-1:0] positions;
  logic [PW-1:0]   led_number;
  logic [7:0]      i_r, i_g, i_b;
  logic [7:0]      o_r, o_g, o_b;

  multi_player_track_screen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .frame_tick       (frame_tick),
    .positions        (positions),
    .led_number       (led_number),
    .i_red_intensity  (i_r),
    .i_blue_intensity (i_b),
    .i_green_intensity(i_g),
    .o_red_intensity  (o_r),
    .o_blue_intensity (o_b),
    .o_green_intensity(o_g)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int pos  [N];
  int cur  [N];
  int trl  [N];
  int tcnt [N];
  int bcnt;
  bit bon;
  int col_g [N] = '{10, 0, 0, 5};
  int col_r [N] = '{0, 10, 0, 5};
  int col_b [N] = '{0, 0, 10, 0};

  function automatic logic [23:0] grb(input int g, input int r, input int b);
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  function automatic logic [23:0] expect_led(input int led);
    int nhit = 0;
    int who  = 0;
    int mx   = 0;
    for (int p = 0; p < N; p++) if (cur[p] > mx) mx = cur[p];
    for (int p = 0; p < N; p++) begin
      if (cur[p] == led && cur[p] < MAXP) begin
        nhit++;
        who = p;
      end
    end
    if (nhit >= 2) return grb(5, 5, 5);
    if (nhit == 1) begin
      if (mx > 0 && cur[who] == mx && !bon)
        return grb(col_g[who] / 2, col_r[who] / 2, col_b[who] / 2);
      return grb(col_g[who], col_r[who], col_b[who]);
    end
    for (int p = 0; p < N; p++) begin
      if (tcnt[p] > 0 && trl[p] == led && trl[p] < MAXP)
        return grb(col_g[p] / 2, col_r[p] / 2, col_b[p] / 2);
    end
    return 24'h0;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      cur[p]  = 0;
      trl[p]  = 0;
      tcnt[p] = 0;
    end
    bcnt = 0;
    bon  = 1'b1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed GRB=%h expected GRB=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_pos();
    for (int p = 0; p < N; p++) positions[p*PW +: PW] = PW'(pos[p]);
  endtask

  task automatic tick();
    apply_pos();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (pos[p] != cur[p]) begin
        trl[p]  = cur[p];
        cur[p]  = pos[p];
        tcnt[p] = TRAIL;
      end else if (tcnt[p] > 0) begin
        tcnt[p]--;
      end
    end
    if (bcnt == BLINK - 1) begin
      bcnt = 0;
      bon  = !bon;
    end else begin
      bcnt++;
    end
  endtask

  task automatic probe(input string tag, input int led);
    led_number = PW'(led);
    @(posedge clk);
    #1;
    $display("probe %s led=%0d en=%0b out GRB=%h", tag, led, enable, {o_g, o_r, o_b});
    check(tag, {o_g, o_r, o_b}, enable ? expect_led(led) : {i_g, i_r, i_b});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_first", {o_g, o_r, o_b}, 24'h0);
    @(posedge clk);
    #1;
    check("reset_hold", {o_g, o_r, o_b}, 24'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    frame_tick = 1'b0;
    i_r        = 8'd33;
    i_g        = 8'd0;
    i_b        = 8'd7;
    led_number = '0;
    for (int p = 0; p < N; p++) pos[p] = 0;
    apply_pos();
    model_reset();

    // Reset, then pass-through of the upstream bus
    @(posedge clk); #1;
    check("reset_a", {o_g, o_r, o_b}, 24'h0);
    @(posedge clk); #1;
    check("reset_b", {o_g, o_r, o_b}, 24'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("passthru", {o_g, o_r, o_b}, 24'h002107);

    // Everybody on LED 0: collision, no leader
    enable = 1'b1;
    probe("start_led0", 0);

    // Single player, then blink after BLINK frames
    pos[0] = 5;
    tick();
    probe("p0_led5", 5);
    check("p0_direct", {o_g, o_r, o_b}, 24'h0A0000);
    repeat (BLINK - 1) tick();
    probe("blink_low", 5);
    check("blink_direct", {o_g, o_r, o_b}, 24'h050000);

    // Trail: player 1 moves 5 -> 6 once player 0's own trail has faded
    pos[0] = 40;
    pos[1] = 5;
    tick();
    repeat (TRAIL) tick();
    pos[1] = 6;
    tick();
    for (int k = 0; k <= TRAIL; k++) begin
      probe("trail", 5);
      check("trail_direct", {o_g, o_r, o_b}, (k < TRAIL) ? 24'h000500 : 24'h0);
      tick();
    end
    probe("p1_led6", 6);

    // Collision away from the start line
    pos[2] = 20;
    pos[3] = 20;
    tick();
    probe("collide", 20);
    check("collide_direct", {o_g, o_r, o_b}, 24'h050505);

    // Tied leaders across blink phases
    pos[0] = 30;
    pos[1] = 30;
    tick();
    for (int k = 0; k < 20; k++) begin
      probe("tied", 30);
      tick();
    end
    probe("old_trail", 40);

    // Live-input isolation: no capture without a frame tick
    pos[0] = 50;
    apply_pos();
    probe("iso_30", 30);
    probe("iso_50", 50);
    tick();
    probe("iso_after", 50);

    // Randomized mix of moves, ticks, enable toggles, resets and probes
    for (int it = 0; it < 500; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
        for (int p = 0; p < N; p++)
          pos[p] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(109, 127))
                                               : int'($urandom_range(0, 12));
        tick();
      end else if (r < 50) begin
        tick();
      end else if (r < 56) begin
        enable = ($urandom_range(0, 2) != 0);
        i_r = 8'($urandom);
        i_g = 8'($urandom);
        i_b = 8'($urandom);
        probe("rand_en", int'($urandom_range(0, 15)));
      end else if (r < 58) begin
        do_reset();
      end else if (r < 78) begin
        probe("rand_player", cur[$urandom_range(0, N - 1)]);
      end else begin
        probe("rand_led", int'($urandom_range(0, 15)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_player_track_screen.md
# multi_player_track_screen

Parametrised gameplay renderer for the LED race track. It generalises the fixed four-player screen to N players, each with a configurable colour. It adds three sequential effects: frame-synchronous position capture, a fading trail at each player's previous LED, and blinking of the current leader. It sits in the screen manager between the race state and the LED strip driver, on the same per-LED intensity bus as the other screens, and passes that bus through when disabled.

## Interface
Parameters:
- `N_PLAYERS`, 4: number of players, 1..8.
- `MAX_POS`, 109: number of LEDs on the track. Position/LED width `POS_W = $clog2(MAX_POS)`.
- `PLAYER_COLORS`, package default `DEFAULT_COLORS`: 24*N_PLAYERS packed {G,R,B} bytes, player 0 in the LSBs.
- `TRAIL_FRAMES`, 8: frames a trail stays lit after a move; 0 disables trails.
- `BLINK_FRAMES`, 16: frames per blink half-period; 0 disables blinking.
- `COLLISION_LEVEL`, 5: per-channel intensity when two or more players share an LED.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: 1 renders this screen; 0 passes the `i_*` intensities through.
- `frame_tick` in 1: one-cycle pulse at the start of each strip refresh.
- `positions` in N_PLAYERS*POS_W: packed player positions, player 0 in the LSBs.
- `led_number` in POS_W: index of the LED currently being requested by the driver.
- `i_red_intensity`, `i_blue_intensity`, `i_green_intensity` in 8 each: upstream bus.
- `o_red_intensity`, `o_blue_intensity`, `o_green_intensity` out 8 each: registered output bus.

## Operation
- **Per-player state:** `cur_pos`, `trail_pos`, `trail_cnt` (width of TRAIL_FRAMES).
- **Global state:** `blink_cnt` and `blink_on`.
- **On `frame_tick`, per player:**
  - If `positions[p] != cur_pos[p]`: set `trail_pos <= cur_pos`, `cur_pos <= positions[p]`, `trail_cnt <= TRAIL_FRAMES`.
  - Otherwise, if `trail_cnt > 0`, decrement it.
- **Blink counter, on `frame_tick`:**
  - If `blink_cnt == BLINK_FRAMES-1`, clear it and toggle `blink_on`.
  - Otherwise increment it.
- **Frame-stable rendering:** rendering uses only `cur_pos`, never the live `positions`, so there is no tearing within a frame.
- **State updates continue while `enable` = 0.** Effects are already in progress when the screen is re-enabled.
- **Leader set:** every player whose `cur_pos` equals the maximum `cur_pos`, provided that maximum is greater than 0.
  - Ties: all tied players are leaders.
  - All players at 0: no leader.
- **Per-LED render priority, evaluated on `led_number`:**
  1. Two or more players with `cur_pos == led_number`: all three channels = COLLISION_LEVEL.
  2. Exactly one player: that player's colour. If the player is a leader, BLINK_FRAMES ≠ 0 and `blink_on` = 0, every channel is halved (`>>1`, floor).
  3. No player, but one or more trails with `trail_cnt > 0` and `trail_pos == led_number`: the lowest-index such player's colour, each channel `>>1`.
  4. Otherwise all channels 0.
- **Out-of-range positions** (≥ MAX_POS) never match any LED and are not an error.
- **Pass-through:** when `enable` = 0, each `o_*` is the registered `i_*`.

## Timing
- **Output latency:** 1 cycle from `led_number`, `i_*` and `enable`.
- **Frame state:** position, trail and blink state is visible to rendering on the cycle after `frame_tick`.
- **Reset values:** all `o_*` = 0; `cur_pos`, `trail_pos`, `trail_cnt`, `blink_cnt` = 0; `blink_on` = 1.
- **Reset during operation:** all state is cleared. The output is 0 on the cycle after `rst_n` is sampled low, and 0 while `rst_n` stays low. No trail is generated from pre-reset positions.
- **Move back to the trail LED:** a player moving onto its own trail LED is rendered as the player (priority 2), not the trail.
- **Move on the last trail frame:** this restarts the trail at the new previous position.
- **N_PLAYERS = 1:** collision is unreachable. The single player is leader whenever `cur_pos > 0`.
- **Multiple moves between ticks:** only the value present at `frame_tick` is captured; intermediate values are lost by design.

## Structure
- **Package `track_screen_pkg`:**
  - `DEFAULT_COLORS` for 8 players; the first 4 are green 10, red 10, blue 10, yellow {5,5,0}.
  - The `rgb_t` {G,R,B} struct.
  - The `HALF()` intensity helper.
- **Sub-module `player_trail_tracker`:** one instance per player via `generate`. It holds `cur_pos`, `trail_pos` and `trail_cnt`, and outputs `hit` and `trail_hit` for the current `led_number`.
- **Top level:** the leader compare, blink counter, priority mux and output register.

## Test plan
- **Reset and pass-through:** reset, then `enable` = 0 with `i_red` = 33. Expect all `o_*` = 0 during reset, then `o_red` = 33 one cycle later.
- **Single player, blink:** player 0 at position 5 with the other players at 0, then `frame_tick`. Expect LED 5 = {10,0,0} GRB. After BLINK_FRAMES ticks (leader, `blink_on` = 0), expect LED 5 = {5,0,0}.
- **Trail:** player 1 moves 5 → 6 on a tick. Expect LED 5 = red 5 for 8 ticks, then 0 on the 9th tick.
- **Collision:** players 2 and 3 both at 20. Expect LED 20 = {5,5,5}.
- **Tied leaders:** players 0 and 1 both at 30, both blinking in phase. At start, with all players at 0, expect no blinking.
- **Live-input isolation:** change `positions` mid-frame without a tick. Expect the output unchanged until the next `frame_tick`.
